// File: rtl/dram_access_controller.sv
// dram_access_controller
//   Request-side controller for a small DRAM array. Turns a valid/ready request
//   stream into single-cycle write strobes or two-cycle read accesses on a
//   shared tri-state data bus, and returns read data on a one-cycle pulse.
//   Optional feature macro: DRAM_REFRESH_EN adds a periodic read/write-back
//   refresh sweep over every row.

module dram_access_controller #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4
`ifdef DRAM_REFRESH_EN
  , parameter int REFRESH_INTERVAL = 64
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  inout  wire  [DATA_W-1:0] mem_data,
  output logic              ref_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD, S_RD_CAP, S_REF_RD, S_REF_CAP, S_REF_WR
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_accept;
  logic              w_ref_pending;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we_n;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rdata;

  assign req_ready = (r_state == S_IDLE) && !w_ref_pending;
  assign w_accept  = req_valid && req_ready;

  assign mem_addr  = r_addr;
  assign mem_we    = r_we_n;
  // The bus enable is the inverse of the registered write strobe, so the
  // controller can never drive while the DRAM is being read.
  assign mem_data  = r_we_n ? {DATA_W{1'bz}} : r_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;

`ifdef DRAM_REFRESH_EN
  localparam int CNT_W = $clog2(REFRESH_INTERVAL);

  logic [CNT_W-1:0] r_ref_cnt;
  logic             r_ref_pending;

  // Free-running interval counter; raises a sweep request on each wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ref_cnt     <= '0;
      r_ref_pending <= 1'b0;
    end else begin
      if (r_ref_cnt == CNT_W'(REFRESH_INTERVAL - 1)) begin
        r_ref_cnt     <= '0;
        r_ref_pending <= 1'b1;
      end else begin
        r_ref_cnt <= r_ref_cnt + CNT_W'(1);
        // A pending sweep is consumed on the IDLE cycle that launches it.
        if (r_state == S_IDLE) r_ref_pending <= 1'b0;
      end
    end
  end

  assign w_ref_pending = r_ref_pending;
  assign ref_busy      = (r_state == S_REF_RD) || (r_state == S_REF_CAP) ||
                         (r_state == S_REF_WR);
`else
  assign w_ref_pending = 1'b0;
  assign ref_busy      = 1'b0;
`endif

  // Next-state decode.
  always_comb begin
    // NOTE: default assigned first so every path writes w_next (no latch).
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
`ifdef DRAM_REFRESH_EN
        if (w_ref_pending) w_next = S_REF_RD;
        else
`endif
        if (w_accept) w_next = req_write ? S_WR : S_RD;
      end
      S_WR:      w_next = S_IDLE;
      S_RD:      w_next = S_RD_CAP;
      S_RD_CAP:  w_next = S_IDLE;
`ifdef DRAM_REFRESH_EN
      S_REF_RD:  w_next = S_REF_CAP;
      S_REF_CAP: w_next = S_REF_WR;
      S_REF_WR:  w_next = (r_addr == '1) ? S_IDLE : S_REF_RD;
`endif
      default:   w_next = S_IDLE;
    endcase
  end

  // State register, registered DRAM pins, captured request and read response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only.
      r_state     <= S_IDLE;
      r_we_n      <= 1'b1;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_next;
      r_we_n      <= !((w_next == S_WR) || (w_next == S_REF_WR));
      r_rsp_valid <= (r_state == S_RD_CAP);
      if (r_state == S_RD_CAP) r_rdata <= mem_data;
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
`ifdef DRAM_REFRESH_EN
      if ((r_state == S_IDLE) && w_ref_pending) r_addr <= '0;
      if (r_state == S_REF_CAP) r_wdata <= mem_data;
      if ((r_state == S_REF_WR) && (r_addr != '1)) r_addr <= r_addr + ADDR_W'(1);
`endif
    end
  end

endmodule

// File: tb/tb_dram_access_controller.sv
// Scoreboard bench for dram_access_controller with a behavioural 8x4 DRAM
// array on the shared bus. Refresh scenarios run when DRAM_REFRESH_EN is defined.

module tb_dram_access_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [2:0] req_addr = '0;
  logic [3:0] req_wdata = '0;
  logic       req_ready;
  logic       rsp_valid;
  logic [3:0] rsp_rdata;
  logic [2:0] mem_addr;
  logic       mem_we;
  wire  [3:0] mem_data;
  logic       ref_busy;

  dram_access_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_data  (mem_data),
    .ref_busy  (ref_busy)
  );

  always #5 clk = ~clk;

  // DRAM array model: drives the bus only while mem_we is high, writes on
  // rising edges while mem_we is low.
  logic [3:0] dram [8];
  assign mem_data = (mem_we == 1'b1) ? dram[mem_addr] : 4'bzzzz;
  always @(posedge clk) if (mem_we == 1'b0) dram[mem_addr] <= mem_data;

  typedef struct {
    logic [3:0] data;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   ref_wr_cnt = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rst_n && mem_we == 1'b0 && ref_busy) ref_wr_cnt <= ref_wr_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every response and watches the bus.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_rdata", 32'(rsp_rdata), 32'(e.data));
          check("rsp_latency", 32'(cyc - e.cyc), 32'd3);
        end
      end
      if (mem_we == 1'b1) check("bus_read_undriven", 32'(mem_data), 32'(dram[mem_addr]));
    end
  end

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_req(input bit wr, input logic [2:0] a, input logic [3:0] d,
                        input logic [3:0] exp_rd);
    int guard = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) check("req_accept_timeout", 32'(guard), 32'd0);
    else if (!wr) sb.push_back('{exp_rd, cyc});
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("rsp_missing", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) dram[i] = '0;

    // 1: reset in the middle of a read
    do_reset(3);
    mon_en = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd2;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mem_we", 32'(mem_we), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_ref_busy", 32'(ref_busy), 32'd0);

    // 3: back-to-back writes with req_valid held high
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i % 2 == 0) begin
        req_valid = 1'b1; req_write = 1'b1;
        req_addr = 3'(i / 2); req_wdata = 4'(i / 2) ^ 4'h5;
        check("b2b_ready_hi", 32'(req_ready), 32'd1);
        check("b2b_we_idle", 32'(mem_we), 32'd1);
      end else begin
        req_addr = 3'd7; req_wdata = 4'hF;
        check("b2b_ready_lo", 32'(req_ready), 32'd0);
        check("b2b_we_strobe", 32'(mem_we), 32'd0);
        check("b2b_bus_data", 32'(mem_data), 32'((i / 2) ^ 5));
        check("b2b_bus_addr", 32'(mem_addr), 32'(i / 2));
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_we_after", 32'(mem_we), 32'd1);

    // 2: write i to row i, read back
    for (int i = 0; i < 8; i++) do_req(1'b1, 3'(i), 4'(i), 4'h0);
    for (int i = 0; i < 8; i++) do_req(1'b0, 3'(i), 4'h0, 4'(i));
    drain();

`ifdef DRAM_REFRESH_EN
    // 5: refresh sweep preserves contents
    begin
      int guard = 0;
      int busy_cnt = 1;
      int wr_start;
      for (int i = 0; i < 8; i++) do_req(1'b1, 3'(i), 4'hA ^ 4'(i), 4'h0);
      @(negedge clk);
      while (ref_busy && guard < 100) begin @(negedge clk); guard++; end
      guard = 0;
      while (!ref_busy && guard < 200) begin @(negedge clk); guard++; end
      check("ref_start_seen", 32'(ref_busy), 32'd1);
      wr_start = ref_wr_cnt;
      @(negedge clk);
      while (ref_busy && busy_cnt < 100) begin busy_cnt++; @(negedge clk); end
      check("ref_busy_cycles", 32'(busy_cnt), 32'd24);
      check("ref_wr_count", 32'(ref_wr_cnt - wr_start), 32'd8);
      for (int i = 0; i < 8; i++) do_req(1'b0, 3'(i), 4'h0, 4'hA ^ 4'(i));
      drain();
    end

    // 6: read issued in the cycle the refresh becomes pending
    begin
      int waited = 0;
      int busy_seen = 0;
      do_reset(2);
      repeat (64) @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd3;
      while (!req_ready && waited < 100) begin
        if (ref_busy) busy_seen++;
        waited++;
        @(negedge clk);
      end
      check("ref_hold_cycles", 32'(waited), 32'd25);
      check("ref_hold_busy", 32'(busy_seen), 32'd24);
      if (req_ready) sb.push_back('{4'hA ^ 4'h3, cyc});
      @(posedge clk);
      #1 req_valid = 1'b0;
      drain();
    end
`else
    // Without refresh, an idle controller stays ready and never sweeps.
    repeat (100) begin
      @(negedge clk);
      if (ref_busy || !req_ready) break;
    end
    check("noref_busy", 32'(ref_busy), 32'd0);
    check("noref_ready", 32'(req_ready), 32'd1);
    do_req(1'b0, 3'd5, 4'h0, 4'h5);
    drain();
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
